pdp11_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the S1/S2/S3 decode/execute sequencer.
- Reads 16-bit instruction words from instruction flash through a request/response port and buffers them in a small prefetch FIFO.
- Presents each word with its PC to the decoder over a valid/ready handshake.
- Accepts PC redirects from branch/jump execution, flushes stale words, and flags fetch faults that the simulation bench uses to stop.

---
 rtl/pdp11_fetch_unit.sv | 133 +++++++++++++
 tb/tb_pdp11_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_fetch_unit.sv
// pdp11_fetch_unit: instruction prefetch from flash into a small FIFO feeding the decoder,
// with PC redirect/flush and a sticky fault on odd or out-of-range PCs.
module pdp11_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'o000000,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 2,
    parameter int          ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr_word,
    output logic [15:0]       instr_pc,
    input  logic              redirect_valid,
    input  logic [15:0]       redirect_pc,
    output logic              fetch_fault
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [16:0] LIMIT = 17'(2 * MEM_WORDS);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} state_t;

    state_t state, state_n;
    logic [15:0] pc, pc_n, req_pc, req_pc_n;
    logic drop, drop_n, fault_n, push, pop, flush, owed, in_range, bad_redirect;
    logic [CW-1:0] cnt, cnt_after;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [15:0] buf_word [FIFO_DEPTH];
    logic [15:0] buf_pc [FIFO_DEPTH];

    assign mem_req      = state == REQ;
    assign mem_addr     = mem_req ? pc[ADDR_W:1] : '0;
    assign instr_valid  = cnt != '0 && state != FAULT;
    assign instr_word   = buf_word[rd_ptr];
    assign instr_pc     = buf_pc[rd_ptr];
    assign pop          = instr_valid && instr_ready && !redirect_valid;
    assign in_range     = {1'b0, pc} < LIMIT;
    assign bad_redirect = redirect_pc[0] || {1'b0, redirect_pc} >= LIMIT;
    // A response is still owed if a request goes out this cycle or one is pending and not arriving now
    assign owed = state == REQ || (state == WAIT && !mem_rvalid) || (state == FAULT && drop && !mem_rvalid);

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        req_pc_n  = req_pc;
        drop_n    = drop;
        fault_n   = fetch_fault;
        push      = 1'b0;
        flush     = 1'b0;
        cnt_after = cnt + CW'(mem_rvalid && !drop) - CW'(pop);
        case (state)
            IDLE: begin
                // Out-of-range faults wait until earlier words have drained to the decoder
                if (fetch_en && !fetch_fault && (cnt - CW'(pop)) < DEPTH) begin
                    if (in_range) begin
                        state_n = REQ;
                    end else if (cnt == '0) begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                    end
                end
            end
            REQ: begin
                req_pc_n = pc;
                pc_n     = pc + 16'd2;
                state_n  = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    push    = !drop;
                    drop_n  = 1'b0;
                    state_n = (fetch_en && in_range && cnt_after < DEPTH) ? REQ : IDLE;
                end
            end
            FAULT: begin
                if (mem_rvalid) drop_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
        if (redirect_valid) begin
            flush   = 1'b1;
            push    = 1'b0;
            pc_n    = redirect_pc;
            drop_n  = owed;
            fault_n = bad_redirect;
            state_n = bad_redirect ? FAULT : owed ? WAIT : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_pc      <= '0;
            drop        <= 1'b0;
            fetch_fault <= 1'b0;
            cnt         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_word[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            req_pc      <= req_pc_n;
            drop        <= drop_n;
            fetch_fault <= fault_n;
            if (flush) begin
                cnt    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    buf_word[wr_ptr] <= mem_rdata;
                    buf_pc[wr_ptr]   <= req_pc;
                    wr_ptr           <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_pdp11_fetch_unit.sv
// tb_pdp11_fetch_unit: flash model with programmable latency, scoreboard of expected
// decoder words and flash addresses, plus a table of redirect vectors.
module tb_pdp11_fetch_unit;
    logic        clk = 0, reset_n = 0, fetch_en = 0, mem_rvalid = 0, instr_ready = 0, redirect_valid = 0;
    logic [15:0] mem_rdata = 0, redirect_pc = 0;
    logic        mem_req, instr_valid, fetch_fault;
    logic [9:0]  mem_addr;
    logic [15:0] instr_word, instr_pc;

    typedef struct { logic [15:0] word; logic [15:0] pc; } exp_t;
    typedef struct { logic [15:0] rpc; logic fault; } vec_t;

    exp_t        exp_q[$];
    logic [9:0]  addr_q[$];
    logic [15:0] flash [1024];
    vec_t        vt [6];
    int vectors = 0, misses = 0, req_cnt = 0, lat = 1, timer = 0;
    logic [9:0]  pend = 0;
    logic        inject = 0;

    pdp11_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Flash model: answers each request lat cycles later; inject forces a stray response
    always @(negedge clk) begin
        mem_rvalid = 0;
        if (!reset_n) timer = 0;
        if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                mem_rvalid = 1;
                mem_rdata  = flash[pend];
            end
        end
        if (inject) begin
            mem_rvalid = 1;
            mem_rdata  = 16'hDEAD;
            inject     = 0;
        end
        if (mem_req && reset_n) begin
            timer = lat;
            pend  = mem_addr;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_req) begin
                req_cnt++;
                if (addr_q.size() > 0) begin
                    logic [9:0] a;
                    a = addr_q.pop_front();
                    vectors++;
                    if (mem_addr !== a) begin
                        misses++;
                        $display("FAIL mem_addr: got %0d expected %0d", mem_addr, a);
                    end
                end
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    misses++;
                    $display("FAIL unexpected_word: got word %o pc %o, none expected", instr_word, instr_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (instr_word !== e.word || instr_pc !== e.pc) begin
                        misses++;
                        $display("FAIL decode_word: got word %o pc %o expected word %o pc %o",
                                 instr_word, instr_pc, e.word, e.pc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] pc);
        exp_q.push_back('{word: flash[pc[10:1]], pc: pc});
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while (exp_q.size() > 0 && k < 300) begin
            tick(1);
            k++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic redirect(input logic [15:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1;
        tick(1);
        redirect_valid = 0;
    endtask

    task automatic quiesce();
        fetch_en    = 0;
        instr_ready = 0;
        tick(8);
        redirect(16'd0);
        tick(8);
        addr_q.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_mem_req"}, mem_req, 0);
        chk({name, "_mem_addr"}, mem_addr, 0);
        chk({name, "_instr_valid"}, instr_valid, 0);
        chk({name, "_instr_word"}, instr_word, 0);
        chk({name, "_instr_pc"}, instr_pc, 0);
        chk({name, "_fetch_fault"}, fetch_fault, 0);
    endtask

    initial begin
        int r, k;
        for (int i = 0; i < 1024; i++) flash[i] = 16'(i) ^ 16'h5A00;
        flash[0] = 16'o005000; flash[1] = 16'o005200; flash[2] = 16'o060001; flash[3] = 16'o000000;
        vt[0] = '{16'o000101, 1'b1};
        vt[1] = '{16'o000200, 1'b0};
        vt[2] = '{16'd2048,   1'b1};
        vt[3] = '{16'd2046,   1'b0};
        vt[4] = '{16'hFFFE,   1'b1};
        vt[5] = '{16'o000100, 1'b0};

        tick(2);
        chk_all_zero("reset");
        reset_n = 1;
        tick(1);

        // Sequential fetch, latency 1
        for (int i = 0; i < 4; i++) begin
            expect_word(16'(2 * i));
            addr_q.push_back(10'(i));
        end
        lat = 1; instr_ready = 1; fetch_en = 1;
        wait_empty("seq");
        quiesce();

        // Backpressure: FIFO fills with two words and requests stop
        lat = 3; r = req_cnt; fetch_en = 1;
        tick(20);
        chk("bp_req_count", req_cnt - r, 2);
        chk("bp_valid", instr_valid, 1);
        chk("bp_head_pc", instr_pc, 0);
        for (int i = 0; i < 6; i++) expect_word(16'(2 * i));
        instr_ready = 1;
        wait_empty("bp");
        quiesce();

        // Redirect while the read for pc 4 is outstanding
        lat = 2;
        expect_word(16'd0); expect_word(16'd2);
        instr_ready = 1; fetch_en = 1;
        k = 0;
        while (!(mem_req && mem_addr == 10'd2) && k < 50) begin
            tick(1);
            k++;
        end
        chk("rd_saw_req4", mem_req, 1);
        tick(1);
        addr_q.push_back(10'd32);
        expect_word(16'o000100); expect_word(16'o000102);
        redirect(16'o000100);
        chk("rd_flushed", instr_valid, 0);
        wait_empty("rd");
        quiesce();

        // Redirect table: odd / out-of-range faults and clean resumes
        lat = 1; fetch_en = 1;
        foreach (vt[i]) begin
            redirect(vt[i].rpc);
            chk($sformatf("vec%0d_fault", i), fetch_fault, vt[i].fault);
            chk($sformatf("vec%0d_valid", i), instr_valid, 0);
            if (vt[i].fault) begin
                r = req_cnt;
                tick(5);
                chk($sformatf("vec%0d_no_req", i), req_cnt - r, 0);
            end else begin
                k = 0;
                while (!mem_req && k < 10) begin
                    tick(1);
                    k++;
                end
                chk($sformatf("vec%0d_req", i), mem_req, 1);
                chk($sformatf("vec%0d_addr", i), mem_addr, 32'(vt[i].rpc >> 1));
            end
        end
        quiesce();

        // Run off the end of flash
        redirect(16'd2040);
        for (int i = 0; i < 4; i++) expect_word(16'(2040 + 2 * i));
        r = req_cnt; instr_ready = 1; fetch_en = 1;
        wait_empty("oor");
        tick(5);
        chk("oor_fault", fetch_fault, 1);
        tick(10);
        chk("oor_req_count", req_cnt - r, 4);
        chk("oor_valid", instr_valid, 0);
        quiesce();

        // Async reset in the middle of a read, then a stale response
        lat = 3; fetch_en = 1;
        k = 0;
        while (!mem_req && k < 10) begin
            tick(1);
            k++;
        end
        tick(1);
        fetch_en = 0;
        #2 reset_n = 0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1 reset_n = 1;
        inject = 1;
        tick(3);
        chk("stale_dropped", instr_valid, 0);
        addr_q.push_back(10'd0);
        expect_word(16'd0);
        instr_ready = 1; fetch_en = 1;
        wait_empty("post_rst");
        instr_ready = 0; fetch_en = 0;
        chk("post_rst_addr_seen", addr_q.size(), 0);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
